// File: rtl/fu_wb_arbiter_if.sv
// Result type shared by the functional units and writeback, plus the bundle of FU-result and writeback handshakes.
// slave modport faces the arbiter; master modport faces the units and writeback consumer.
package fu_wb_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [5:0]  prd;
    logic [31:0] rdval;
  } fu_output_t;
endpackage

interface fu_wb_arbiter_if #(
  parameter int NB_FU = 4
);
  import fu_wb_pkg::*;

  localparam int SRC_W = $clog2(NB_FU);

  logic [NB_FU-1:0] fu_valid_i;
  fu_output_t       fu_result_i [NB_FU];
  logic [NB_FU-1:0] fu_ready_o;
  logic             wb_valid_o;
  fu_output_t       wb_o;
  logic [SRC_W-1:0] wb_src_o;
  logic             wb_ready_i;

  modport master (
    output fu_valid_i, fu_result_i, wb_ready_i,
    input  fu_ready_o, wb_valid_o, wb_o, wb_src_o
  );

  modport slave (
    input  fu_valid_i, fu_result_i, wb_ready_i,
    output fu_ready_o, wb_valid_o, wb_o, wb_src_o
  );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Per-unit result FIFOs drained round-robin onto one registered writeback port; 2-cycle latency, 1 with FU_WB_BYPASS_EN.
// Backpressure: wb_ready_i low freezes wb_o/wb_src_o/wb_valid_o; fu_ready_o[i] drops only while FIFO i is full.
module fu_wb_fifo
  import fu_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  fu_output_t               push_dat,
  input  logic                     pop,
  output fu_output_t               head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fu_output_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fu_wb_arbiter
  import fu_wb_pkg::*;
#(
  parameter int NB_FU = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  fu_wb_arbiter_if.slave   bus
);
  localparam int SRC_W = $clog2(NB_FU);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [CW-1:0]    count [NB_FU];
  fu_output_t       head  [NB_FU];
  logic [NB_FU-1:0] nonempty;
  logic [NB_FU-1:0] ready;
  logic [NB_FU-1:0] cand;
  logic [NB_FU-1:0] push;
  logic [NB_FU-1:0] pop;
  logic [NB_FU-1:0] bypass_take;

  logic             wb_valid;
  fu_output_t       wb_dat;
  logic [SRC_W-1:0] wb_src;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_nxt;
  logic             free;
  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;
  fu_output_t       grant_dat;

  assign free = !wb_valid || bus.wb_ready_i;

  for (genvar g = 0; g < NB_FU; g++) begin : g_unit
    fu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (push[g]),
      .push_dat (bus.fu_result_i[g]),
      .pop      (pop[g]),
      .head_dat (head[g]),
      .count    (count[g])
    );

    assign nonempty[g] = (count[g] != '0);
    // A full FIFO stays not-ready even when it pops this cycle.
    assign ready[g]    = (count[g] != CW'(DEPTH));
`ifdef FU_WB_BYPASS_EN
    assign cand[g]        = nonempty[g] | bus.fu_valid_i[g];
    assign bypass_take[g] = free & grant_vld & (grant_idx == SRC_W'(g)) & ~nonempty[g];
`else
    assign cand[g]        = nonempty[g];
    assign bypass_take[g] = 1'b0;
`endif
    assign push[g] = bus.fu_valid_i[g] & ready[g] & ~bypass_take[g];
    assign pop[g]  = free & grant_vld & (grant_idx == SRC_W'(g)) & nonempty[g];
  end

  // Walk from the lowest priority back to rr_ptr so the last hit is the winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NB_FU - 1; k >= 0; k--) begin
      if (cand[(int'(rr_ptr) + k) % NB_FU]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'((int'(rr_ptr) + k) % NB_FU);
      end
    end
  end

  always_comb begin
    grant_dat = nonempty[grant_idx] ? head[grant_idx] : bus.fu_result_i[grant_idx];
    rr_nxt    = (int'(grant_idx) == NB_FU - 1) ? '0 : grant_idx + SRC_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_dat   <= '0;
      wb_src   <= '0;
      rr_ptr   <= '0;
    end else if (free) begin
      wb_valid <= grant_vld;
      if (grant_vld) begin
        wb_dat <= grant_dat;
        wb_src <= grant_idx;
        rr_ptr <= rr_nxt;
      end
    end
  end

  assign bus.fu_ready_o = ready;
  assign bus.wb_valid_o = wb_valid;
  assign bus.wb_o       = wb_dat;
  assign bus.wb_src_o   = wb_src;
endmodule
